// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory.
// Port 0 (MEM stage) has priority; port 1 (stack engine) is forced after STARVE_LIMIT grants.
module dmem_arbiter #(
    parameter int unsigned N            = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [15:0] addr0,
    input  logic [15:0] wdata0,
    output logic        done0,
    output logic [15:0] rdata0,
    output logic        err0,
    output logic        stall0,
    input  logic        req1,
    input  logic        we1,
    input  logic        len1,
    input  logic [15:0] addr1,
    input  logic [31:0] wdata1,
    output logic        done1,
    output logic [31:0] rdata1,
    output logic        err1,
    output logic        mem_re,
    output logic        mem_we,
    output logic [15:0] mem_raddr,
    output logic [15:0] mem_waddr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

    state_t        state;
    logic          port_q;
    logic          we_q;
    logic          len_q;
    logic          beat_q;
    logic          err_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_hi_q;
    logic [15:0]   rbuf_lo;
    logic [CW-1:0] starve;

    logic          grant1;
    logic          sel_we;
    logic [15:0]   sel_addr;
    logic [15:0]   sel_wdata;
    logic [15:0]   beat1_addr;
    logic [15:0]   cur_addr;
    logic [15:0]   cap_val;
    logic [31:0]   rbuf_next;

    function automatic logic in_range(input logic [15:0] a);
        return (32'(a) >> N) == 32'd0;
    endfunction

    always_comb begin
        grant1     = req1 & (~req0 | (starve == CW'(STARVE_LIMIT)));
        sel_we     = grant1 ? we1 : we0;
        sel_addr   = grant1 ? addr1 : addr0;
        sel_wdata  = grant1 ? wdata1[15:0] : wdata0;
        beat1_addr = addr_q + 16'd1;
        cur_addr   = beat_q ? beat1_addr : addr_q;
        // Writes and out-of-range beats contribute zero to the read buffer.
        cap_val    = (!we_q && in_range(cur_addr)) ? mem_rdata : '0;
        rbuf_next  = beat_q ? {cap_val, rbuf_lo} : {16'h0000, cap_val};
    end

    assign stall0 = req0 & ~done0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            len_q      <= 1'b0;
            beat_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_hi_q <= '0;
            rbuf_lo    <= '0;
            starve     <= '0;
            done0      <= 1'b0;
            rdata0     <= '0;
            err0       <= 1'b0;
            done1      <= 1'b0;
            rdata1     <= '0;
            err1       <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_raddr  <= '0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        port_q     <= grant1;
                        we_q       <= sel_we;
                        len_q      <= grant1 & len1;
                        beat_q     <= 1'b0;
                        addr_q     <= sel_addr;
                        wdata_hi_q <= wdata1[31:16];
                        err_q      <= ~in_range(sel_addr);
                        if (in_range(sel_addr)) begin
                            if (sel_we) begin
                                mem_we    <= 1'b1;
                                mem_waddr <= sel_addr;
                                mem_wdata <= sel_wdata;
                            end else begin
                                mem_re    <= 1'b1;
                                mem_raddr <= sel_addr;
                            end
                        end
                        if (grant1 || !req1) begin
                            starve <= '0;
                        end else if (starve != CW'(STARVE_LIMIT)) begin
                            starve <= starve + 1'b1;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    if (len_q && !beat_q) begin
                        rbuf_lo <= cap_val;
                        beat_q  <= 1'b1;
                        err_q   <= err_q | ~in_range(beat1_addr);
                        if (in_range(beat1_addr)) begin
                            if (we_q) begin
                                mem_we    <= 1'b1;
                                mem_waddr <= beat1_addr;
                                mem_wdata <= wdata_hi_q;
                            end else begin
                                mem_re    <= 1'b1;
                                mem_raddr <= beat1_addr;
                            end
                        end
                        state <= ACCESS;
                    end else begin
                        if (port_q) begin
                            done1  <= 1'b1;
                            rdata1 <= rbuf_next;
                            err1   <= err_q;
                        end else begin
                            done0  <= 1'b1;
                            rdata0 <= rbuf_next[15:0];
                            err0   <= err_q;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model with per-cycle compare, plus directed scenarios.
// A second instance with N = 16 exercises the 0xFFFF -> 0x0000 beat wrap.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0, len1 = 0;
    logic [15:0] addr0 = 0, wdata0 = 0, addr1 = 0;
    logic [31:0] wdata1 = 0;
    logic        done0, err0, stall0, done1, err1, mem_re, mem_we;
    logic [15:0] rdata0, mem_raddr, mem_waddr, mem_wdata;
    logic [31:0] rdata1;
    logic [15:0] mem_rdata = '0;

    logic        b_req0 = 0, b_we0 = 0, b_req1 = 0, b_we1 = 0, b_len1 = 0;
    logic [15:0] b_addr0 = 0, b_wdata0 = 0, b_addr1 = 0;
    logic [31:0] b_wdata1 = 0;
    logic        b_done0, b_err0, b_stall0, b_done1, b_err1, b_mem_re, b_mem_we;
    logic [15:0] b_rdata0, b_mem_raddr, b_mem_waddr, b_mem_wdata;
    logic [31:0] b_rdata1;
    logic [15:0] b_mem_rdata = '0;

    logic        pre_we = 0;
    logic [15:0] pre_a = 0, pre_d = 0;

    int errors = 0;
    int checks = 0;
    int tb_cyc = 0;

    dmem_arbiter #(.N(10), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .done0(done0), .rdata0(rdata0), .err0(err0), .stall0(stall0),
        .req1(req1), .we1(we1), .len1(len1), .addr1(addr1), .wdata1(wdata1),
        .done1(done1), .rdata1(rdata1), .err1(err1),
        .mem_re(mem_re), .mem_we(mem_we), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.N(16), .STARVE_LIMIT(LIMIT)) dut16 (
        .clk(clk), .rst(rst),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
        .done0(b_done0), .rdata0(b_rdata0), .err0(b_err0), .stall0(b_stall0),
        .req1(b_req1), .we1(b_we1), .len1(b_len1), .addr1(b_addr1), .wdata1(b_wdata1),
        .done1(b_done1), .rdata1(b_rdata1), .err1(b_err1),
        .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_raddr(b_mem_raddr), .mem_waddr(b_mem_waddr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // Memories: write and read-address register at posedge, read data presented at negedge.
    logic [15:0] m10 [0:65535];
    logic [15:0] m16 [0:65535];
    logic [15:0] ra10 = 0, ra16 = 0;
    logic        rp10 = 0, rp16 = 0;

    always @(posedge clk) begin
        if (pre_we) m10[pre_a] <= pre_d;
        else if (mem_we) m10[mem_waddr] <= mem_wdata;
        rp10 <= mem_re;
        if (mem_re) ra10 <= mem_raddr;
    end
    always @(negedge clk) if (rp10) mem_rdata <= m10[ra10];

    always @(posedge clk) begin
        if (b_mem_we) m16[b_mem_waddr] <= b_mem_wdata;
        rp16 <= b_mem_re;
        if (b_mem_re) ra16 <= b_mem_raddr;
    end
    always @(negedge clk) if (rp16) b_mem_rdata <= m16[ra16];

    logic        rec16 = 0;
    int          rn = 0;
    logic [15:0] rlog [0:3];
    always @(posedge clk) begin
        if (rec16 && b_mem_re && rn < 4) begin
            rlog[rn] <= b_mem_raddr;
            rn <= rn + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model of the N = 10 instance: one transaction at a time,
    // done after 2*beats+1 cycles, next arbitration one idle cycle later.
    logic [15:0] ref10 [0:65535];
    bit          ref_ok [0:65535];
    int          m_cyc = 0, m_done_at = 0, m_next = 0, m_starve = 0;
    bit          m_pend = 0, m_port = 0, m_err = 0;
    logic [31:0] m_res = 0;
    logic        e_done0 = 0, e_done1 = 0, e_err0 = 0, e_err1 = 0;
    logic [15:0] e_rd0 = 0;
    logic [31:0] e_rd1 = 0;

    always @(posedge clk or negedge rst) begin : model
        bit          w, wr;
        int          nb;
        logic [15:0] a, d;
        if (!rst) begin
            m_pend = 0; m_starve = 0; m_next = 0;
            e_done0 = 0; e_done1 = 0; e_err0 = 0; e_err1 = 0; e_rd0 = 0; e_rd1 = 0;
        end else begin
            m_cyc = m_cyc + 1;
            e_done0 = 0;
            e_done1 = 0;
            if (m_pend && m_cyc == m_done_at) begin
                m_pend = 0;
                if (m_port) begin e_done1 = 1; e_rd1 = m_res; e_err1 = m_err; end
                else begin e_done0 = 1; e_rd0 = m_res[15:0]; e_err0 = m_err; end
            end
            if (pre_we) begin ref10[pre_a] = pre_d; ref_ok[pre_a] = 1; end
            if (m_cyc >= m_next && (req0 || req1)) begin
                w  = (req0 && req1) ? (m_starve == LIMIT) : req1;
                nb = (w && len1) ? 2 : 1;
                wr = w ? we1 : we0;
                m_res = 0;
                m_err = 0;
                for (int b = 0; b < nb; b++) begin
                    a = w ? addr1 + 16'(b) : addr0;
                    d = w ? ((b == 0) ? wdata1[15:0] : wdata1[31:16]) : wdata0;
                    if (a >= 16'h0400) m_err = 1;
                    else if (wr) begin ref10[a] = d; ref_ok[a] = 1; end
                    else if (b == 0) m_res[15:0] = ref10[a];
                    else m_res[31:16] = ref10[a];
                end
                m_starve = (w || !req1) ? 0 : ((m_starve < LIMIT) ? m_starve + 1 : LIMIT);
                m_port = w;
                m_pend = 1;
                m_done_at = m_cyc + 2 * nb;
                m_next = m_cyc + 2 * nb + 2;
            end
        end
    end

    always @(negedge clk) begin
        chk("done0", done0, e_done0);
        chk("done1", done1, e_done1);
        chk("rdata0", rdata0, e_rd0);
        chk("err0", err0, e_err0);
        chk("rdata1", rdata1, e_rd1);
        chk("err1", err1, e_err1);
        chk("stall0", stall0, req0 & ~e_done0);
        if (mem_re || mem_we) chk("mem_re_we_excl", mem_re & mem_we, 0);
        if (mem_re) chk("mem_raddr_range", mem_raddr < 16'h0400, 1);
        if (mem_we) chk("mem_waddr_range", mem_waddr < 16'h0400, 1);
    end

    task automatic p0(input logic w, input logic [15:0] a, input logic [15:0] d, output int lat);
        int  start;
        bit  seen;
        @(posedge clk); #1;
        req0 = 1; we0 = w; addr0 = a; wdata0 = d;
        start = tb_cyc;
        seen = 0;
        lat = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done0) begin seen = 1; lat = tb_cyc - start; end
        end
        chk("p0_done_seen", seen, 1);
        @(posedge clk); #1;
        req0 = 0;
    endtask

    task automatic p1(input logic w, input logic l, input logic [15:0] a, input logic [31:0] d,
                      output int lat);
        int  start;
        bit  seen;
        @(posedge clk); #1;
        req1 = 1; we1 = w; len1 = l; addr1 = a; wdata1 = d;
        start = tb_cyc;
        seen = 0;
        lat = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done1) begin seen = 1; lat = tb_cyc - start; end
        end
        chk("p1_done_seen", seen, 1);
        @(posedge clk); #1;
        req1 = 0;
    endtask

    task automatic pb(input logic w, input logic [15:0] a, input logic [31:0] d, output int lat);
        int  start;
        bit  seen;
        @(posedge clk); #1;
        b_req1 = 1; b_we1 = w; b_len1 = 1; b_addr1 = a; b_wdata1 = d;
        start = tb_cyc;
        seen = 0;
        lat = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (b_done1) begin seen = 1; lat = tb_cyc - start; end
        end
        chk("pb_done_seen", seen, 1);
        @(posedge clk); #1;
        b_req1 = 0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout: errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat, n, cnt, mism;
        int order [0:9];
        int exp_order [0:9];
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        #1 rst = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_raddr", mem_raddr, 0);
        chk("rst_mem_waddr", mem_waddr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata1", rdata1, 0);
        @(posedge clk); #1 rst = 1;

        // 1: port 0 write then read
        p0(1, 16'h0005, 16'h1234, lat);
        chk("t1_wr_latency", lat, 3);
        fork
            p0(0, 16'h0005, 16'h0000, lat);
            begin @(posedge clk); #2; chk("t1_stall0_pending", stall0, 1); end
        join
        chk("t1_rd_latency", lat, 3);
        chk("t1_rdata0", rdata0, 16'h1234);
        chk("t1_err0", err0, 0);

        // 2: port 1 two-word write then read
        p1(1, 1, 16'h0010, 32'hBEEF_CAFE, lat);
        chk("t2_wr_latency", lat, 5);
        chk("t2_mem_lo", m10[16'h0010], 16'hCAFE);
        chk("t2_mem_hi", m10[16'h0011], 16'hBEEF);
        p1(0, 1, 16'h0010, 32'h0, lat);
        chk("t2_rd_latency", lat, 5);
        chk("t2_rdata1", rdata1, 32'hBEEF_CAFE);
        p1(0, 0, 16'h0011, 32'h0, lat);
        chk("t2_len0_rdata1", rdata1, 32'h0000_BEEF);

        // 3: both ports held high
        @(posedge clk); #1;
        req0 = 1; we0 = 0; addr0 = 16'h0005;
        req1 = 1; we1 = 0; len1 = 0; addr1 = 16'h0010;
        n = 0;
        for (int i = 0; i < 80 && n < 10; i++) begin
            @(negedge clk);
            if (done0 && n < 10) begin order[n] = 0; n++; end
            if (done1 && n < 10) begin order[n] = 1; n++; end
        end
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        chk("t3_grant_count", n, 10);
        for (int i = 0; i < 10; i++) chk($sformatf("t3_grant_%0d", i), order[i], exp_order[i]);

        // 4: out-of-range beats with N = 10
        @(posedge clk); #1;
        pre_we = 1; pre_a = 16'h0400; pre_d = 16'h7777;
        @(posedge clk); #1;
        pre_we = 0;
        p1(1, 1, 16'h03FF, 32'h5555_AAAA, lat);
        chk("t4_err1", err1, 1);
        chk("t4_mem_3ff", m10[16'h03FF], 16'hAAAA);
        chk("t4_mem_400", m10[16'h0400], 16'h7777);
        p0(0, 16'h0400, 16'h0, lat);
        chk("t4_rdata0", rdata0, 16'h0000);
        chk("t4_err0", err0, 1);

        // 5: reset during ACCESS of a port-0 write
        @(posedge clk); #1;
        req0 = 1; we0 = 1; addr0 = 16'h0020; wdata0 = 16'hABCD;
        @(posedge clk); #1;
        chk("t5_in_access", mem_we, 1);
        #1 rst = 0;
        #1 chk("t5_mem_we_async", mem_we, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1;
        cnt = 0;
        for (int i = 0; i < 20 && cnt == 0; i++) begin
            @(negedge clk);
            if (done0) cnt++;
        end
        @(posedge clk); #1 req0 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done0) cnt++;
        end
        chk("t5_done0_once", cnt, 1);
        chk("t5_mem", m10[16'h0020], 16'hABCD);

        // 6: wrap of beat 1 address with N = 16
        pb(1, 16'hFFFF, 32'h2222_1111, lat);
        chk("t6_mem_ffff", m16[16'hFFFF], 16'h1111);
        chk("t6_mem_0000", m16[16'h0000], 16'h2222);
        rec16 = 1;
        pb(0, 16'hFFFF, 32'h0, lat);
        rec16 = 0;
        chk("t6_latency", lat, 5);
        chk("t6_rdata1", b_rdata1, 32'h2222_1111);
        chk("t6_err1", b_err1, 0);
        chk("t6_read_beats", rn, 2);
        chk("t6_raddr0", rlog[0], 16'hFFFF);
        chk("t6_raddr1", rlog[1], 16'h0000);

        mism = 0;
        for (int i = 0; i < 65536; i++) begin
            if (ref_ok[i] && m10[i] !== ref10[i]) mism++;
        end
        chk("mem_image", mism, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the single-ported data memory (16-bit words, registered read, output updated on negedge). Port 0 is the pipeline MEM stage: single-word load/store, stalls the pipe while pending. Port 1 is the stack/interrupt engine: one- or two-word accesses for 32-bit PC push/pop on CALL/RET/INT. The block owns every memory control signal and sequences multi-beat accesses; neither requester drives the memory directly.

Parameters:
N, 10, memory depth is 2^N words; addresses with any bit at or above bit N set are out of range.
STARVE_LIMIT, 4, consecutive port-0 grants allowed while port 1 waits before port 1 is forced.

Ports:
clk  in  1  clock; all state changes on posedge.
rst  in  1  asynchronous, active-low reset (0 = reset).
req0  in  1  port 0 request; held with fields stable until done0.
we0  in  1  port 0: 1 = write, 0 = read.
addr0  in  16  port 0 word address.
wdata0  in  16  port 0 write data.
done0  out  1  one-cycle completion pulse.
rdata0  out  16  read data, valid while done0 = 1.
err0  out  1  out-of-range flag, valid while done0 = 1.
stall0  out  1  combinational: req0 & ~done0.
req1  in  1  port 1 request; held with fields stable until done1.
we1  in  1  port 1: 1 = write.
len1  in  1  0 = one word, 1 = two words (addr1, addr1+1).
addr1  in  16  port 1 base word address.
wdata1  in  32  [15:0] written at addr1, [31:16] at addr1+1.
done1  out  1  one-cycle completion pulse.
rdata1  out  32  read data, same word order as wdata1; valid with done1; upper half 0 when len1 = 0.
err1  out  1  any beat out of range; valid with done1.
mem_re  out  1  memory read_enable.
mem_we  out  1  memory write_enable.
mem_raddr  out  16  memory read_addr.
mem_waddr  out  16  memory write_addr.
mem_wdata  out  16  memory write_data.
mem_rdata  in  16  memory_data_output.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE. All outputs 0: mem_re, mem_we, mem_raddr, mem_waddr, mem_wdata, done0/1, err0/1, rdata0/1. Starvation counter 0. Any in-flight access is abandoned without a done pulse. Requesters keep req high, and the request is re-arbitrated after reset is released.
- All outputs are registered except stall0.
- FSM states: IDLE -> ACCESS -> CAPTURE -> (ACCESS for beat 1 | DONE) -> IDLE.
- IDLE: at posedge, if any req is high, pick a winner and latch its we, len, addr, wdata. Drive the memory controls for beat 0 into ACCESS.
- ACCESS (1 cycle): mem_re or mem_we = 1 with beat address and data. Write: mem_waddr and mem_wdata set. Read: mem_raddr set. The other address is held at its previous value.
- CAPTURE (1 cycle): mem_re = mem_we = 0. mem_rdata is valid from the negedge in this cycle and is captured at the posedge ending CAPTURE into the beat's half of the read buffer.
- DONE (1 cycle): done of the granted port = 1, with rdata and err. Requests are not sampled in DONE. The next arbitration happens in the following IDLE cycle.
- Latency, counted from the posedge sampling req in IDLE:
  - One-word access: done high 3 cycles later.
  - Two-word access: done high 5 cycles later.
- Arbitration: port 0 has fixed priority, except when both request and starve count = STARVE_LIMIT; then port 1 wins.
- Starvation counter:
  - Increments on each port-0 grant while req1 = 1.
  - Clears on a port-1 grant, or at any arbitration where req1 = 0.
  - Saturates at STARVE_LIMIT.
- Address of beat 1 = addr1 + 1, modulo 2^16 (0xFFFF wraps to 0x0000).
- Out-of-range beat: no mem_re or mem_we is issued for that beat, but the ACCESS/CAPTURE slot is still consumed. The read half for that beat is 0, and err is set for the transaction. In-range beats of the same transaction execute normally.
- Writes go through CAPTURE unchanged; no data is captured.
- rdata/err hold their value after done drops and are overwritten only by the next completion on the same port.
- Simultaneous req0 and req1 with the counter below the limit: port 0 is served. Port 1 remains pending and is not dropped.

Test Plan:
1. Port 0 write 0x1234 to 0x0005, then port 0 read 0x0005 -> write done0 3 cycles after sampling; read done0 3 cycles after sampling, rdata0 = 0x1234, err0 = 0; stall0 high from req0 until done0.
2. Port 1 len1 = 1 write 0xBEEFCAFE to 0x0010, then two-word read -> memory holds 0x0010 = 0xCAFE and 0x0011 = 0xBEEF; read done1 5 cycles after sampling with rdata1 = 0xBEEFCAFE.
3. req0 and req1 held high continuously (single-word ops) -> grant order 0,0,0,0,1,0,0,0,0,1; no request lost.
4. N = 10, port 1 two-word write to 0x03FF -> only 0x03FF written, no mem_we for 0x0400, err1 = 1 with done1; port 0 read of 0x0400 -> no mem_re, rdata0 = 0x0000, err0 = 1.
5. rst driven low during ACCESS of a port-0 write -> mem_we = 0 immediately (before next clk), no done0; after release with req0 still high, the write is re-executed and done0 pulses once.
6. Port 1 two-word read at 0xFFFF with N = 16 -> beats at 0xFFFF then 0x0000; rdata1 = {mem[0x0000], mem[0xFFFF]}.
